// File: rtl/mem_wb_elastic_stage_if.sv
// MEM/WB beat bus: upstream handshake, head beat toward WB, forwarding tap
// and stall counter, grouped for the mem_wb_elastic_stage port list.
interface mem_wb_elastic_stage_if #(
  parameter int DATA_W      = 128,
  parameter int REG_AW      = 5,
  parameter int STALL_CNT_W = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_W-1:0]      dm_in;
  logic [DATA_W-1:0]      alu_in;
  logic [REG_AW-1:0]      rd_in;
  logic                   regwrite_in;
  logic                   memtoreg_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      dm_out;
  logic [DATA_W-1:0]      alu_out;
  logic [REG_AW-1:0]      rd_out;
  logic                   regwrite_out;
  logic [DATA_W-1:0]      wb_data;
  logic                   fwd_en;
  logic [REG_AW-1:0]      fwd_rd;
  logic [DATA_W-1:0]      fwd_data;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport slave (
    input  in_valid, dm_in, alu_in, rd_in,
    input  regwrite_in, memtoreg_in, out_ready,
    output in_ready, out_valid, dm_out, alu_out,
    output rd_out, regwrite_out, wb_data,
    output fwd_en, fwd_rd, fwd_data, stall_cnt
  );

  modport master (
    output in_valid, dm_in, alu_in, rd_in,
    output regwrite_in, memtoreg_in, out_ready,
    input  in_ready, out_valid, dm_out, alu_out,
    input  rd_out, regwrite_out, wb_data,
    input  fwd_en, fwd_rd, fwd_data, stall_cnt
  );
endinterface

// File: rtl/mem_wb_elastic_stage.sv
// MEM/WB elastic stage: valid/ready, sync flush, x0 suppression, fwd tap.
// MEMWB_SKID_EN adds a skid entry so in_ready is registered.
module mem_wb_elastic_stage #(
  parameter int DATA_W      = 128,
  parameter int REG_AW      = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  mem_wb_elastic_stage_if.slave bus
);
  logic                   hd_vld_q, hd_vld_d;
  logic [DATA_W-1:0]      hd_dm_q, hd_dm_d;
  logic [DATA_W-1:0]      hd_alu_q, hd_alu_d;
  logic [REG_AW-1:0]      hd_rd_q, hd_rd_d;
  logic                   hd_rw_q, hd_rw_d;
  logic                   hd_mtr_q, hd_mtr_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   in_rw;
  logic                   accept;
  logic                   consume;

  assign in_rw   = bus.regwrite_in & (bus.rd_in != '0);
  assign accept  = bus.in_valid & bus.in_ready;
  assign consume = hd_vld_q & bus.out_ready;

`ifdef MEMWB_SKID_EN
  logic              sk_vld_q, sk_vld_d;
  logic [DATA_W-1:0] sk_dm_q, sk_dm_d;
  logic [DATA_W-1:0] sk_alu_q, sk_alu_d;
  logic [REG_AW-1:0] sk_rd_q, sk_rd_d;
  logic              sk_rw_q, sk_rw_d;
  logic              sk_mtr_q, sk_mtr_d;

  assign bus.in_ready = !sk_vld_q;

  always_comb begin
    hd_vld_d = hd_vld_q;
    hd_dm_d  = hd_dm_q;
    hd_alu_d = hd_alu_q;
    hd_rd_d  = hd_rd_q;
    hd_rw_d  = hd_rw_q;
    hd_mtr_d = hd_mtr_q;
    sk_vld_d = sk_vld_q;
    sk_dm_d  = sk_dm_q;
    sk_alu_d = sk_alu_q;
    sk_rd_d  = sk_rd_q;
    sk_rw_d  = sk_rw_q;
    sk_mtr_d = sk_mtr_q;
    // skid full implies in_ready=0, so a skid promote never races an accept
    if (consume & sk_vld_q) begin
      hd_vld_d = 1'b1;
      hd_dm_d  = sk_dm_q;
      hd_alu_d = sk_alu_q;
      hd_rd_d  = sk_rd_q;
      hd_rw_d  = sk_rw_q;
      hd_mtr_d = sk_mtr_q;
    end else if (accept & (!hd_vld_q | consume)) begin
      hd_vld_d = 1'b1;
      hd_dm_d  = bus.dm_in;
      hd_alu_d = bus.alu_in;
      hd_rd_d  = bus.rd_in;
      hd_rw_d  = in_rw;
      hd_mtr_d = bus.memtoreg_in;
    end else if (consume) begin
      hd_vld_d = 1'b0;
    end
    if (accept & hd_vld_q & !consume) begin
      sk_vld_d = 1'b1;
      sk_dm_d  = bus.dm_in;
      sk_alu_d = bus.alu_in;
      sk_rd_d  = bus.rd_in;
      sk_rw_d  = in_rw;
      sk_mtr_d = bus.memtoreg_in;
    end else if (consume) begin
      sk_vld_d = 1'b0;
    end
    if (flush) begin
      hd_vld_d = 1'b0;
      sk_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sk_vld_q <= 1'b0;
      sk_dm_q  <= '0;
      sk_alu_q <= '0;
      sk_rd_q  <= '0;
      sk_rw_q  <= 1'b0;
      sk_mtr_q <= 1'b0;
    end else begin
      sk_vld_q <= sk_vld_d;
      sk_dm_q  <= sk_dm_d;
      sk_alu_q <= sk_alu_d;
      sk_rd_q  <= sk_rd_d;
      sk_rw_q  <= sk_rw_d;
      sk_mtr_q <= sk_mtr_d;
    end
  end
`else
  assign bus.in_ready = !hd_vld_q | bus.out_ready;

  always_comb begin
    hd_vld_d = hd_vld_q;
    hd_dm_d  = hd_dm_q;
    hd_alu_d = hd_alu_q;
    hd_rd_d  = hd_rd_q;
    hd_rw_d  = hd_rw_q;
    hd_mtr_d = hd_mtr_q;
    if (accept) begin
      hd_vld_d = 1'b1;
      hd_dm_d  = bus.dm_in;
      hd_alu_d = bus.alu_in;
      hd_rd_d  = bus.rd_in;
      hd_rw_d  = in_rw;
      hd_mtr_d = bus.memtoreg_in;
    end else if (consume) begin
      hd_vld_d = 1'b0;
    end
    if (flush) begin
      hd_vld_d = 1'b0;
    end
  end
`endif

  always_comb begin
    stall_d = stall_q;
    if (hd_vld_q & !bus.out_ready & (stall_q != '1)) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hd_vld_q <= 1'b0;
      hd_dm_q  <= '0;
      hd_alu_q <= '0;
      hd_rd_q  <= '0;
      hd_rw_q  <= 1'b0;
      hd_mtr_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      hd_vld_q <= hd_vld_d;
      hd_dm_q  <= hd_dm_d;
      hd_alu_q <= hd_alu_d;
      hd_rd_q  <= hd_rd_d;
      hd_rw_q  <= hd_rw_d;
      hd_mtr_q <= hd_mtr_d;
      stall_q  <= stall_d;
    end
  end

  assign bus.out_valid    = hd_vld_q;
  assign bus.dm_out       = hd_dm_q;
  assign bus.alu_out      = hd_alu_q;
  assign bus.rd_out       = hd_rd_q;
  assign bus.regwrite_out = hd_rw_q;
  assign bus.wb_data      = hd_mtr_q ? hd_dm_q : hd_alu_q;
  assign bus.fwd_en       = hd_vld_q & hd_rw_q;
  assign bus.fwd_rd       = hd_rd_q;
  assign bus.fwd_data     = bus.wb_data;
  assign bus.stall_cnt    = stall_q;
endmodule

// File: tb/tb_mem_wb_elastic_stage.sv
// Bench for mem_wb_elastic_stage: directed scenarios plus a randomized
// run against a FIFO-capacity reference model.
module tb_mem_wb_elastic_stage;
  localparam int DW  = 128;
  localparam int AW  = 5;
  localparam int SW  = 16;
  localparam int SWS = 4;
`ifdef MEMWB_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] dm;
    logic [DW-1:0] alu;
    logic [AW-1:0] rd;
    logic          rw;
    logic          mtr;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic flush_s;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_wb_elastic_stage_if #(.DATA_W(DW), .REG_AW(AW), .STALL_CNT_W(SW)) bus();
  mem_wb_elastic_stage_if #(.DATA_W(DW), .REG_AW(AW), .STALL_CNT_W(SWS)) sbus();

  mem_wb_elastic_stage #(.DATA_W(DW), .REG_AW(AW), .STALL_CNT_W(SW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus)
  );

  mem_wb_elastic_stage #(.DATA_W(DW), .REG_AW(AW), .STALL_CNT_W(SWS)) dut_s (
    .clk(clk), .reset(reset), .flush(flush_s), .bus(sbus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid    = 1'b0;
    bus.dm_in       = '0;
    bus.alu_in      = '0;
    bus.rd_in       = '0;
    bus.regwrite_in = 1'b0;
    bus.memtoreg_in = 1'b0;
    bus.out_ready   = 1'b0;
    flush           = 1'b0;
  endtask

  task automatic put(input logic [DW-1:0] dm, input logic [DW-1:0] alu,
                     input logic [AW-1:0] rd, input logic rw, input logic mtr);
    bus.in_valid    = 1'b1;
    bus.dm_in       = dm;
    bus.alu_in      = alu;
    bus.rd_in       = rd;
    bus.regwrite_in = rw;
    bus.memtoreg_in = mtr;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    step();
    n_run++;
    if (bus.out_valid !== 1'b0 || bus.stall_cnt !== '0 || bus.alu_out !== '0 ||
        bus.rd_out !== '0 || bus.wb_data !== '0) begin
      n_fail++;
      $display("FAIL reset_init: out_valid=%b stall=%0d rd=%0d got nonzero, want all 0",
               bus.out_valid, bus.stall_cnt, bus.rd_out);
    end
    reset = 1'b0;
    step();
    put('0, DW'(5), 5'd3, 1'b1, 1'b0);
    step();
    bus.in_valid = 1'b0;
    step();
    n_run++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre: out_valid=%b want 1", bus.out_valid);
    end
    #2 reset = 1'b1;
    #1;
    n_run++;
    if (bus.out_valid !== 1'b0 || bus.stall_cnt !== '0 || bus.alu_out !== '0 ||
        bus.rd_out !== '0 || bus.fwd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: out_valid=%b stall=%0d alu=%0h rd=%0d fwd_en=%b want all 0",
               bus.out_valid, bus.stall_cnt, bus.alu_out, bus.rd_out, bus.fwd_en);
    end
    step();
    reset = 1'b0;
    #1;
    n_run++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: in_ready=%b want 1", bus.in_ready);
    end
  endtask

  task automatic test_stream();
    idle();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      put('0, DW'(i), AW'(i + 1), 1'b1, 1'b0);
      step();
      n_run++;
      if (bus.out_valid !== 1'b1 || bus.alu_out !== DW'(i) ||
          bus.rd_out !== AW'(i + 1) || bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_%0d: valid=%b alu=%0h rd=%0d rdy=%b want 1/%0h/%0d/1",
                 i, bus.out_valid, bus.alu_out, bus.rd_out, bus.in_ready, i, i + 1);
      end
    end
    bus.in_valid = 1'b0;
    step();
    n_run++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_drain: out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_back_pressure();
    idle();
    do_reset();
    put('0, DW'('hA0), 5'd4, 1'b1, 1'b0);
    step();
    put('0, DW'('hB0), 5'd5, 1'b1, 1'b0);
    #1;
    n_run++;
    if (bus.in_ready !== SKID) begin
      n_fail++;
      $display("FAIL bp_ready_head: in_ready=%b want %b", bus.in_ready, SKID);
    end
    step();
    if (SKID) bus.in_valid = 1'b0;
    n_run++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_ready_full: in_ready=%b want 0", bus.in_ready);
    end
    for (int i = 0; i < 4; i++) step();
    n_run++;
    if (bus.stall_cnt !== SW'(5) || bus.out_valid !== 1'b1 || bus.alu_out !== DW'('hA0)) begin
      n_fail++;
      $display("FAIL bp_hold: stall=%0d valid=%b alu=%0h want 5/1/a0",
               bus.stall_cnt, bus.out_valid, bus.alu_out);
    end
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    n_run++;
    if (bus.out_valid !== 1'b1 || bus.alu_out !== DW'('hB0) || bus.rd_out !== 5'd5) begin
      n_fail++;
      $display("FAIL bp_second: valid=%b alu=%0h rd=%0d want 1/b0/5",
               bus.out_valid, bus.alu_out, bus.rd_out);
    end
    step();
    n_run++;
    if (bus.out_valid !== 1'b0 || bus.stall_cnt !== SW'(5)) begin
      n_fail++;
      $display("FAIL bp_done: valid=%b stall=%0d want 0/5", bus.out_valid, bus.stall_cnt);
    end
  endtask

  task automatic test_x0_select();
    idle();
    bus.out_ready = 1'b1;
    put(DW'('hAA), DW'('h55), 5'd0, 1'b1, 1'b1);
    step();
    n_run++;
    if (bus.out_valid !== 1'b1 || bus.regwrite_out !== 1'b0 || bus.fwd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_suppress: valid=%b rw=%b fwd_en=%b want 1/0/0",
               bus.out_valid, bus.regwrite_out, bus.fwd_en);
    end
    n_run++;
    if (bus.wb_data !== DW'('hAA) || bus.fwd_data !== DW'('hAA)) begin
      n_fail++;
      $display("FAIL sel_dm: wb=%0h fwd=%0h want aa", bus.wb_data, bus.fwd_data);
    end
    put(DW'('hAA), DW'('h55), 5'd3, 1'b1, 1'b0);
    step();
    n_run++;
    if (bus.regwrite_out !== 1'b1 || bus.fwd_en !== 1'b1 || bus.fwd_rd !== 5'd3 ||
        bus.wb_data !== DW'('h55)) begin
      n_fail++;
      $display("FAIL sel_alu: rw=%b fwd_en=%b fwd_rd=%0d wb=%0h want 1/1/3/55",
               bus.regwrite_out, bus.fwd_en, bus.fwd_rd, bus.wb_data);
    end
    bus.in_valid = 1'b0;
    step();
    n_run++;
    if (bus.fwd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_idle: fwd_en=%b want 0", bus.fwd_en);
    end
  endtask

  task automatic test_flush();
    idle();
    do_reset();
    put('0, DW'('hC0), 5'd6, 1'b1, 1'b0);
    step();
    put('0, DW'('hD0), 5'd7, 1'b1, 1'b0);
    flush = 1'b1;
    step();
    n_run++;
    if (bus.out_valid !== 1'b0 || bus.stall_cnt !== SW'(1)) begin
      n_fail++;
      $display("FAIL flush_stalled: valid=%b stall=%0d want 0/1", bus.out_valid, bus.stall_cnt);
    end
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_run++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_ghost_%0d: valid=%b want 0", i, bus.out_valid);
      end
    end
    bus.out_ready = 1'b0;
    put('0, DW'('hC2), 5'd8, 1'b1, 1'b0);
    step();
    put('0, DW'('hD2), 5'd9, 1'b1, 1'b0);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    n_run++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_accept: valid=%b want 0", bus.out_valid);
    end
    step();
    n_run++;
    if (bus.out_valid !== 1'b0 || bus.stall_cnt !== SW'(1)) begin
      n_fail++;
      $display("FAIL flush_after: valid=%b stall=%0d want 0/1", bus.out_valid, bus.stall_cnt);
    end
  endtask

  task automatic test_random();
    beat_t         q[$];
    beat_t         b;
    beat_t         h;
    int            exp_stall;
    logic          exp_rdy;
    logic          acc;
    logic          con;
    idle();
    do_reset();
    exp_stall = 0;
    for (int c = 0; c < 400; c++) begin
      bus.in_valid    = ($urandom_range(0, 3) != 0);
      bus.out_ready   = ($urandom_range(0, 2) != 0);
      flush           = ($urandom_range(0, 31) == 0);
      bus.dm_in       = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.alu_in      = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.rd_in       = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
      bus.regwrite_in = $urandom_range(0, 1) != 0;
      bus.memtoreg_in = $urandom_range(0, 1) != 0;
      #2;
      exp_rdy = SKID ? (q.size() < 2) : (q.size() == 0 || bus.out_ready);
      n_run++;
      if (bus.in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL rnd_ready c%0d: in_ready=%b want %b", c, bus.in_ready, exp_rdy);
      end
      n_run++;
      if (bus.out_valid !== (q.size() != 0)) begin
        n_fail++;
        $display("FAIL rnd_valid c%0d: out_valid=%b want %b", c, bus.out_valid, q.size() != 0);
      end
      if (q.size() != 0) begin
        h = q[0];
        n_run++;
        if ({bus.dm_out, bus.alu_out, bus.rd_out, bus.regwrite_out} !==
            {h.dm, h.alu, h.rd, h.rw}) begin
          n_fail++;
          $display("FAIL rnd_head c%0d: alu=%h rd=%0d rw=%b want alu=%h rd=%0d rw=%b",
                   c, bus.alu_out, bus.rd_out, bus.regwrite_out, h.alu, h.rd, h.rw);
        end
        n_run++;
        if (bus.wb_data !== (h.mtr ? h.dm : h.alu) || bus.fwd_en !== h.rw) begin
          n_fail++;
          $display("FAIL rnd_wb c%0d: wb=%h fwd_en=%b want wb=%h fwd_en=%b",
                   c, bus.wb_data, bus.fwd_en, h.mtr ? h.dm : h.alu, h.rw);
        end
      end
      n_run++;
      if (bus.stall_cnt !== SW'(exp_stall)) begin
        n_fail++;
        $display("FAIL rnd_stall c%0d: stall=%0d want %0d", c, bus.stall_cnt, exp_stall);
      end
      acc = bus.in_valid && exp_rdy;
      con = (q.size() != 0) && bus.out_ready;
      if (q.size() != 0 && !bus.out_ready && exp_stall < (1 << SW) - 1) exp_stall++;
      b.dm  = bus.dm_in;
      b.alu = bus.alu_in;
      b.rd  = bus.rd_in;
      b.rw  = bus.regwrite_in && (bus.rd_in != 0);
      b.mtr = bus.memtoreg_in;
      if (flush) begin
        q.delete();
      end else begin
        if (con) void'(q.pop_front());
        if (acc) q.push_back(b);
      end
      step();
    end
    idle();
  endtask

  task automatic test_saturation();
    idle();
    sbus.in_valid    = 1'b1;
    sbus.alu_in      = DW'('h77);
    sbus.rd_in       = 5'd2;
    sbus.regwrite_in = 1'b1;
    sbus.out_ready   = 1'b0;
    do_reset();
    step();
    sbus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    n_run++;
    if (sbus.stall_cnt !== SWS'(10)) begin
      n_fail++;
      $display("FAIL sat_mid: stall=%0d want 10", sbus.stall_cnt);
    end
    for (int i = 0; i < 10; i++) step();
    n_run++;
    if (sbus.stall_cnt !== SWS'(15)) begin
      n_fail++;
      $display("FAIL sat_hold: stall=%0d want 15", sbus.stall_cnt);
    end
    flush_s = 1'b1;
    step();
    flush_s = 1'b0;
    step();
    n_run++;
    if (sbus.stall_cnt !== SWS'(15) || sbus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_flush: stall=%0d valid=%b want 15/0", sbus.stall_cnt, sbus.out_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    flush_s          = 1'b0;
    sbus.in_valid    = 1'b0;
    sbus.dm_in       = '0;
    sbus.alu_in      = '0;
    sbus.rd_in       = '0;
    sbus.regwrite_in = 1'b0;
    sbus.memtoreg_in = 1'b0;
    sbus.out_ready   = 1'b1;
    idle();
    test_reset();
    test_stream();
    test_back_pressure();
    test_x0_select();
    test_flush();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
